// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-writable word RAM.
package ram_pkg;

  typedef enum logic {INIT, RUN} ram_state_e;

  localparam int RD_LAT_MAX = 4;

  // One byte lane of a strobed write: take the new byte only when its enable is set.
  function automatic logic [7:0] be_merge(input logic [7:0] old,
                                          input logic [7:0] wdata,
                                          input logic       be);
    return be ? wdata : old;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-response shift register of {valid, err, data}; STAGES cycles of latency.
// Data/err only advance alongside a valid bit, so the last stage holds its value between responses.
module ram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic [STAGES-1:0] vld_q;
  logic              err_q [STAGES];
  logic [DATA_W-1:0] dat_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        err_q[s] <= 1'b0;
        dat_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        err_q[0] <= in_err;
        dat_q[0] <= in_data;
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          err_q[s] <= err_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];
  assign out_data  = dat_q[STAGES-1];

endmodule

// File: rtl/ram_bytewise.sv
// Single-port word RAM with byte strobes, valid/ready requests and optional zero-fill after reset.
// Read latency RD_LAT cycles from accept edge; writes have no response.
// req_ready is low during reset and the zero-fill sweep; responses are never backpressured.
module ram_bytewise
  import ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int RD_LAT         = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_e       state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx;
  logic             sweep_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) state <= INIT;
      else                     state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sweep_we = 1'b0;
    case (state)
      INIT: begin
        sweep_we = 1'b1;
        if (32'(cnt) == DEPTH - 1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN:     state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  assign req_ready = (state == RUN) && !reset;
  assign init_busy = (state == INIT);

  // Upper address bits only take part in the range check, so no aliasing past DEPTH.
  logic             in_range, acc, wr_en, rd_en;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] rd_word;

  assign in_range = 32'(req_addr) < DEPTH;
  assign idx      = req_addr[IDX_W-1:0];
  assign acc      = req_valid && req_ready;
  assign wr_en    = acc && req_we && in_range;
  assign rd_en    = acc && !req_we;
  assign rd_word  = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (sweep_we && !reset) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE_W; i++)
        mem[idx][8*i +: 8] <= be_merge(mem[idx][8*i +: 8], req_wdata[8*i +: 8], req_be[i]);
    end
  end

  // Stage 0 of the pipe is the synchronous read register of the array.
  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en),
    .in_err    (!in_range),
    .in_data   (rd_word),
    .out_valid (rsp_valid),
    .out_err   (rsp_err),
    .out_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_ram_bytewise.sv
// Five RAM instances share one request stream: DEPTH=12/RD_LAT=2 and DEPTH=16 with RD_LAT=1..4.
module tb_ram_bytewise;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic        req_ready_w [N];
  logic        rsp_valid_w [N];
  logic [31:0] rsp_rdata_w [N];
  logic        rsp_err_w   [N];
  logic        init_busy_w [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_bytewise #(
      .DATA_W         (32),
      .ADDR_W         (5),
      .DEPTH          ((g == 0) ? 12 : 16),
      .RD_LAT         ((g == 0) ? 2 : g),
      .CLEAR_ON_RESET (1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready_w[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid_w[g]),
      .rsp_rdata (rsp_rdata_w[g]),
      .rsp_err   (rsp_err_w[g]),
      .init_busy (init_busy_w[g])
    );
  end

  always #5 clk = ~clk;

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : i;
  endfunction

  function automatic int depth_of(int i);
    return (i == 0) ? 12 : 16;
  endfunction

  typedef struct {
    int          issue;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  drop;
  } exp_t;

  typedef struct {
    logic        vld;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] xd;
  } vec_t;

  exp_t        exps[$];
  vec_t        tbl[$];
  int          head [N];
  logic [31:0] last_data [N];
  logic        last_err  [N];
  int          total = 0;
  int          bad = 0;
  int          edge_n = 0;
  bit          armed = 1'b0;
  bit          rst_hit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      rst_hit = 1'b1;
      armed   = 1'b1;
    end
  end

  // Response checker: expected read results are due issue+RD_LAT; otherwise outputs must be idle and held.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_hit) begin
        for (int i = 0; i < N; i++) begin
          last_data[i] = '0;
          last_err[i]  = 1'b0;
        end
        rst_hit = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        while (head[i] < exps.size() && exps[head[i]].drop[i]) head[i]++;
        if (head[i] < exps.size() && exps[head[i]].issue + lat_of(i) < edge_n) begin
          total++;
          bad++;
          $display("FAIL missed_rsp[%0d]: got=none want=addr %0d", i, exps[head[i]].addr);
          head[i]++;
        end
        if (head[i] < exps.size() && exps[head[i]].issue + lat_of(i) == edge_n) begin
          logic        e_err;
          logic [31:0] e_dat;
          e_err = (32'(exps[head[i]].addr) >= depth_of(i));
          e_dat = e_err ? 32'h0 : exps[head[i]].data;
          check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'd1);
          check($sformatf("rsp_rdata[%0d]", i), rsp_rdata_w[i], e_dat);
          check($sformatf("rsp_err[%0d]", i), 32'(rsp_err_w[i]), 32'(e_err));
          last_data[i] = e_dat;
          last_err[i]  = e_err;
          head[i]++;
        end else begin
          check($sformatf("idle_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'd0);
          check($sformatf("hold_rdata[%0d]", i), rsp_rdata_w[i], last_data[i]);
          check($sformatf("hold_err[%0d]", i), 32'(rsp_err_w[i]), 32'(last_err[i]));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic we, input logic [4:0] a,
                       input logic [31:0] wd, input logic [3:0] b, input logic [31:0] xd);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = b;
    if (v) begin
      for (int i = 0; i < N; i++)
        check($sformatf("req_ready[%0d]", i), 32'(req_ready_w[i]), 32'd1);
      if (!we) exps.push_back('{edge_n, a, xd, 5'b0});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts init_busy cycles after reset release; ready must rise the cycle after the sweep ends.
  task automatic wait_init(input string tag);
    int c0 = 0;
    int c1 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (init_busy_w[0]) c0++;
      if (init_busy_w[1]) c1++;
      if (!init_busy_w[0] && !init_busy_w[1]) break;
    end
    check({tag, "_busy_cycles_d12"}, c0, 12);
    check({tag, "_busy_cycles_d16"}, c1, 16);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_ready_after_init[%0d]", tag, i), 32'(req_ready_w[i]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic we, input logic [4:0] a,
                     input logic [31:0] wd, input logic [3:0] b, input logic [31:0] xd);
    tbl.push_back('{v, we, a, wd, b, xd});
  endtask

  initial begin
    int r;
    for (int i = 0; i < N; i++) begin
      head[i]      = 0;
      last_data[i] = '0;
      last_err[i]  = 1'b0;
    end

    for (int i = 0; i < 16; i++) add(1, 0, 5'(i), 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) add(1, 1, 5'(i), 32'hA5A5A5A5 + 32'(i), 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) add(1, 0, 5'(i), 32'h0, 4'h0, 32'hA5A5A5A5 + 32'(i));
    add(0, 0, 5'd0,  32'h0,        4'h0,    32'h0);
    add(0, 0, 5'd0,  32'h0,        4'h0,    32'h0);
    add(1, 1, 5'd3,  32'h11223344, 4'hF,    32'h0);
    add(1, 1, 5'd3,  32'hFFFFFFFF, 4'b0101, 32'h0);
    add(1, 0, 5'd3,  32'h0,        4'h0,    32'h11FF33FF);
    add(1, 1, 5'd4,  32'h00000000, 4'h0,    32'h0);
    add(1, 0, 5'd4,  32'h0,        4'h0,    32'hA5A5A5A9);
    add(1, 1, 5'd5,  32'hDEADBEEF, 4'hF,    32'h0);
    add(1, 0, 5'd5,  32'h0,        4'h0,    32'hDEADBEEF);
    add(1, 1, 5'd12, 32'h12345678, 4'hF,    32'h0);
    add(1, 0, 5'd12, 32'h0,        4'h0,    32'h12345678);
    add(1, 0, 5'd11, 32'h0,        4'h0,    32'h0);
    add(1, 0, 5'd0,  32'h0,        4'h0,    32'hA5A5A5A5);
    add(1, 1, 5'd7,  32'hCAFEF00D, 4'b1010, 32'h0);
    add(1, 0, 5'd7,  32'h0,        4'h0,    32'hCAA5F0AC);
    add(0, 0, 5'd0,  32'h0,        4'h0,    32'h0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init("init1");

    foreach (tbl[j]) drive(tbl[j].vld, tbl[j].we, tbl[j].addr, tbl[j].wdata, tbl[j].be, tbl[j].xd);

    // Reads in flight when reset hits must never surface.
    drive(1, 0, 5'd0, 32'h0, 4'h0, 32'hA5A5A5A5);
    drive(1, 0, 5'd1, 32'h0, 4'h0, 32'hA5A5A5A6);
    drive(1, 0, 5'd2, 32'h0, 4'h0, 32'hA5A5A5A7);
    reset = 1'b1;
    r = edge_n + 1;
    foreach (exps[j])
      for (int i = 0; i < N; i++)
        if (exps[j].issue + lat_of(i) >= r) exps[j].drop[i] = 1'b1;
    @(posedge clk);
    #1;
    check("ready_in_reset", 32'(req_ready_w[1]), 32'd0);
    check("busy_in_reset", 32'(init_busy_w[1]), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Interrupt the sweep part-way; the full sweep length must repeat.
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_sweep", 32'(init_busy_w[1]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init("init2");

    drive(1, 0, 5'd3,  32'h0, 4'h0, 32'h0);
    drive(1, 0, 5'd12, 32'h0, 4'h0, 32'h0);
    drive(1, 0, 5'd9,  32'h0, 4'h0, 32'h0);
    repeat (6) drive(0, 0, 5'd0, 32'h0, 4'h0, 32'h0);

    for (int i = 0; i < N; i++)
      check($sformatf("all_rsp_seen[%0d]", i), head[i], exps.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
